// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, redirect-source codes and
// the NOP encoding used for IF/ID bubbles.
package mips_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0]  PC_SRC_JUMP   = 2'b10;
    localparam logic [31:0] NOP_INST      = 32'h0000_0000;

    // J-type target: region bits of the delay-slot PC, then the word index.
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble and overrides the write enable.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        flush,
    input  logic [31:0] inst_d,
    input  logic [31:0] pc_plus4_d,
    input  logic        valid_d,
    output logic [31:0] inst,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst     <= NOP_INST;
            pc_plus4 <= 32'h0;
            valid    <= 1'b0;
        end else if (flush) begin
            inst     <= NOP_INST;
            pc_plus4 <= 32'h0;
            valid    <= 1'b0;
        end else if (we) begin
            inst     <= inst_d;
            pc_plus4 <= pc_plus4_d;
            valid    <= valid_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem fetch FSM and IF/ID load.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  imem,
    input  logic        pc_ld,
    input  logic        IF_ID_write,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    output logic [31:0] IF_ID_inst,
    output logic [31:0] IF_ID_pc_plus4,
    output logic        IF_ID_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  hold_inst;
    logic [31:0]  avail_inst;
    logic         avail;
    logic         consume;

    assign pc_plus4   = pc + 32'd4;
    assign avail      = ((state == WAIT) && imem.imem_valid) || (state == HOLD);
    assign avail_inst = (state == HOLD) ? hold_inst : imem.imem_rdata;
    assign consume    = avail && IF_ID_write && pc_ld && !flush;

    assign imem.imem_req  = (state == REQ) && !flush && !rst;
    assign imem.imem_addr = pc;

    // With IF_ID_write high and nothing consumed, the register loads a bubble.
    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .we         (IF_ID_write),
        .flush      (flush),
        .inst_d     (consume ? avail_inst : NOP_INST),
        .pc_plus4_d (consume ? pc_plus4 : 32'h0),
        .valid_d    (consume),
        .inst       (IF_ID_inst),
        .pc_plus4   (IF_ID_pc_plus4),
        .valid      (IF_ID_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            hold_inst <= NOP_INST;
        end else if (flush) begin
            pc <= (pc_src == PC_SRC_JUMP) ? jump_target(IF_ID_pc_plus4[31:28], jump_index)
                                          : branch_target;
            // An in-flight response that has not arrived yet must be swallowed in DROP.
            state <= ((state == WAIT || state == DROP) && !imem.imem_valid) ? DROP : REQ;
        end else begin
            if (consume)
                pc <= pc_plus4;
            case (state)
                REQ:  state <= WAIT;
                WAIT: if (imem.imem_valid) begin
                          state     <= consume ? REQ : HOLD;
                          hold_inst <= imem.imem_rdata;
                      end
                HOLD: if (consume) state <= REQ;
                DROP: if (imem.imem_valid) state <= REQ;
                default: state <= REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (consume)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (flush || (IF_ID_write && !consume))
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    assign fetch_count  = 32'h0;
    assign bubble_count = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table for the fetch/stall/flush scenarios,
// an async-reset sequence, then random stimulus against a transaction-level model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_ld, IF_ID_write, flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] IF_ID_inst, IF_ID_pc_plus4, fetch_count, bubble_count;
    logic        IF_ID_valid;
    logic [31:0] ifid2_inst, ifid2_pc4, fc2, bc2;
    logic        ifid2_valid;

    if_stage_if bus ();
    if_stage_if bus2 ();

    if_stage dut (
        .clk(clk), .rst(rst), .imem(bus), .pc_ld(pc_ld), .IF_ID_write(IF_ID_write),
        .flush(flush), .pc_src(pc_src), .branch_target(branch_target),
        .jump_index(jump_index), .IF_ID_inst(IF_ID_inst), .IF_ID_pc_plus4(IF_ID_pc_plus4),
        .IF_ID_valid(IF_ID_valid), .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    // Second instance starting at the top of the address space, always fetching.
    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem(bus2), .pc_ld(1'b1), .IF_ID_write(1'b1),
        .flush(1'b0), .pc_src(2'b00), .branch_target(32'h0), .jump_index(26'h0),
        .IF_ID_inst(ifid2_inst), .IF_ID_pc_plus4(ifid2_pc4), .IF_ID_valid(ifid2_valid),
        .fetch_count(fc2), .bubble_count(bc2)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h2108_0001 + addr;
    endfunction

    // Reference model: one request in flight or not, whether it is stale,
    // and an optional parked instruction.
    logic [31:0] m_pc, m_buf, m_inst, m_pc4, m_fetch, m_bub;
    bit          m_out, m_drop, m_buf_v, m_valid;

    function automatic void model_reset();
        m_pc = 32'h0; m_out = 0; m_drop = 0; m_buf_v = 0; m_buf = 0;
        m_inst = 0; m_pc4 = 0; m_valid = 0; m_fetch = 0; m_bub = 0;
    endfunction

    function automatic void model_step(input bit fl, pl, wr, input logic [1:0] ps,
                                       input logic [31:0] bt, input logic [25:0] ji,
                                       input bit v, input logic [31:0] rd, input bit req);
        bit          have = 0;
        logic [31:0] inst = 0;
        if (fl) begin
            m_pc    = (ps == 2'b10) ? {m_pc4[31:28], ji, 2'b00} : bt;
            m_buf_v = 0;
            m_inst  = 0; m_pc4 = 0; m_valid = 0;
            m_bub   = m_bub + 1;
            if (m_out && v) begin m_out = 0; m_drop = 0; end
            else if (m_out) m_drop = 1;
        end else begin
            if (m_buf_v) begin have = 1; inst = m_buf; end
            if (m_out && v) begin
                m_out = 0;
                if (m_drop) m_drop = 0;
                else begin have = 1; inst = rd; end
            end
            if (have && wr && pl) begin
                m_inst = inst; m_pc4 = m_pc + 4; m_valid = 1;
                m_pc = m_pc + 4; m_buf_v = 0; m_fetch = m_fetch + 1;
            end else begin
                if (have) begin m_buf_v = 1; m_buf = inst; end
                if (wr) begin m_inst = 0; m_pc4 = 0; m_valid = 0; m_bub = m_bub + 1; end
            end
            if (req) m_out = 1;
        end
    endfunction

    function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef FETCH_PERF_CNT_EN
        return c;
`else
        return 32'h0 & c;
`endif
    endfunction

    // Memory models: main one with per-request latency, wrap instance with latency 1.
    bit          mem_busy, pend2;
    int          mem_wait;
    logic [31:0] mem_addr, pend2_addr;
    logic        s_req, s_req2;
    logic [31:0] s_addr, s_addr2;

    task automatic cycle(input bit fl, pl, wr, input logic [1:0] ps, input logic [31:0] bt,
                         input logic [25:0] ji, input int lat);
        bit          v = 0;
        bit          ereq;
        logic [31:0] rd = 0;
        if (mem_busy) begin
            if (mem_wait == 0) begin v = 1; rd = mem_word(mem_addr); mem_busy = 0; end
            else mem_wait--;
        end
        flush = fl; pc_ld = pl; IF_ID_write = wr; pc_src = ps;
        branch_target = bt; jump_index = ji;
        bus.imem_valid = v; bus.imem_rdata = rd;
        bus2.imem_valid = pend2; bus2.imem_rdata = mem_word(pend2_addr); pend2 = 0;
        #1;
        ereq = !m_out && !m_buf_v && !fl;
        s_req = bus.imem_req; s_addr = bus.imem_addr;
        s_req2 = bus2.imem_req; s_addr2 = bus2.imem_addr;
        check("imem_req", {31'h0, s_req}, {31'h0, ereq});
        check("imem_addr", s_addr, m_pc);
        if (ereq) begin mem_busy = 1; mem_wait = lat - 1; mem_addr = m_pc; end
        if (s_req2) begin pend2 = 1; pend2_addr = s_addr2; end
        model_step(fl, pl, wr, ps, bt, ji, v, rd, ereq);
        @(negedge clk);
        check("ifid_inst", IF_ID_inst, m_inst);
        check("ifid_pc4", IF_ID_pc_plus4, m_pc4);
        check("ifid_valid", {31'h0, IF_ID_valid}, {31'h0, m_valid});
        check("fetch_count", fetch_count, cnt_exp(m_fetch));
        check("bubble_count", bubble_count, cnt_exp(m_bub));
    endtask

    typedef struct {
        bit          fl, pl, wr;
        logic [1:0]  ps;
        logic [31:0] bt;
        logic [25:0] ji;
        int          lat;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_inst, e_pc4;
    } vec_t;

    function automatic vec_t mk(input bit fl, pl, wr, input logic [1:0] ps,
                                input logic [31:0] bt, input logic [25:0] ji, input int lat,
                                input bit e_req, input logic [31:0] e_addr, input bit e_valid,
                                input logic [31:0] e_inst, e_pc4);
        vec_t r;
        r.fl = fl; r.pl = pl; r.wr = wr; r.ps = ps; r.bt = bt; r.ji = ji; r.lat = lat;
        r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid;
        r.e_inst = e_inst; r.e_pc4 = e_pc4;
        return r;
    endfunction

    function automatic vec_t nrm(input int lat, input bit e_req, input logic [31:0] e_addr,
                                 input bit e_valid, input logic [31:0] e_inst, e_pc4);
        return mk(0, 1, 1, 2'b00, 32'h0, 26'h0, lat, e_req, e_addr, e_valid, e_inst, e_pc4);
    endfunction

    vec_t vec [21];

    initial begin
        // Fetch 0 and 4, stall over the response for 8, branch flush with a pending
        // response, jump flush coincident with a response, then 3-cycle latency bubbles.
        vec[0]  = nrm(1, 1, 32'h00, 0, 32'h0, 32'h0);
        vec[1]  = nrm(1, 0, 32'h00, 1, 32'h2108_0001, 32'h4);
        vec[2]  = nrm(1, 1, 32'h04, 0, 32'h0, 32'h0);
        vec[3]  = nrm(1, 0, 32'h04, 1, 32'h2108_0005, 32'h8);
        vec[4]  = nrm(1, 1, 32'h08, 0, 32'h0, 32'h0);
        vec[5]  = mk(0, 0, 0, 2'b00, 32'h0, 26'h0, 1, 0, 32'h08, 0, 32'h0, 32'h0);
        vec[6]  = mk(0, 0, 0, 2'b00, 32'h0, 26'h0, 1, 0, 32'h08, 0, 32'h0, 32'h0);
        vec[7]  = mk(0, 0, 0, 2'b00, 32'h0, 26'h0, 1, 0, 32'h08, 0, 32'h0, 32'h0);
        vec[8]  = nrm(1, 0, 32'h08, 1, 32'h2108_0009, 32'hC);
        vec[9]  = nrm(3, 1, 32'h0C, 0, 32'h0, 32'h0);
        vec[10] = mk(1, 1, 1, 2'b01, 32'h40, 26'h0, 1, 0, 32'h0C, 0, 32'h0, 32'h0);
        vec[11] = nrm(1, 0, 32'h40, 0, 32'h0, 32'h0);
        vec[12] = nrm(1, 0, 32'h40, 0, 32'h0, 32'h0);
        vec[13] = nrm(1, 1, 32'h40, 0, 32'h0, 32'h0);
        vec[14] = mk(1, 1, 1, 2'b10, 32'h80, 26'h10, 1, 0, 32'h40, 0, 32'h0, 32'h0);
        vec[15] = nrm(3, 1, 32'h40, 0, 32'h0, 32'h0);
        vec[16] = nrm(1, 0, 32'h40, 0, 32'h0, 32'h0);
        vec[17] = nrm(1, 0, 32'h40, 0, 32'h0, 32'h0);
        vec[18] = nrm(1, 0, 32'h40, 1, 32'h2108_0041, 32'h44);
        vec[19] = nrm(1, 1, 32'h44, 0, 32'h0, 32'h0);
        vec[20] = nrm(1, 0, 32'h44, 1, 32'h2108_0045, 32'h48);

        rst = 1'b1; flush = 0; pc_ld = 1; IF_ID_write = 1; pc_src = 0;
        branch_target = 0; jump_index = 0;
        bus.imem_valid = 0; bus.imem_rdata = 0; bus2.imem_valid = 0; bus2.imem_rdata = 0;
        mem_busy = 0; mem_wait = 0; mem_addr = 0; pend2 = 0; pend2_addr = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_ifid_valid", {31'h0, IF_ID_valid}, 32'h0);
        check("rst_ifid_inst", IF_ID_inst, 32'h0);
        check("rst_wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            cycle(vec[i].fl, vec[i].pl, vec[i].wr, vec[i].ps, vec[i].bt, vec[i].ji, vec[i].lat);
            check($sformatf("vec%0d_req", i), {31'h0, s_req}, {31'h0, vec[i].e_req});
            check($sformatf("vec%0d_addr", i), s_addr, vec[i].e_addr);
            check($sformatf("vec%0d_valid", i), {31'h0, IF_ID_valid}, {31'h0, vec[i].e_valid});
            check($sformatf("vec%0d_inst", i), IF_ID_inst, vec[i].e_inst);
            check($sformatf("vec%0d_pc4", i), IF_ID_pc_plus4, vec[i].e_pc4);
            if (i == 0) check("wrap_addr_first", s_addr2, 32'hFFFF_FFFC);
            if (i == 1) begin
                check("wrap_ifid_pc4", ifid2_pc4, 32'h0);
                check("wrap_ifid_inst", ifid2_inst, mem_word(32'hFFFF_FFFC));
            end
            if (i == 2) check("wrap_addr_second", s_addr2, 32'h0);
        end
        check("tbl_fetch_count", fetch_count, cnt_exp(32'd5));
        check("tbl_bubble_count", bubble_count, cnt_exp(32'd13));

        // Async reset while WAIT holds a valid IF/ID and a slow response is pending.
        cycle(0, 1, 0, 2'b00, 32'h0, 26'h0, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'h0, bus.imem_req}, 32'h0);
        check("arst_addr", bus.imem_addr, 32'h0);
        check("arst_ifid_valid", {31'h0, IF_ID_valid}, 32'h0);
        check("arst_ifid_inst", IF_ID_inst, 32'h0);
        check("arst_ifid_pc4", IF_ID_pc_plus4, 32'h0);
        check("arst_fetch_count", fetch_count, 32'h0);
        check("arst_bubble_count", bubble_count, 32'h0);
        model_reset();
        mem_busy = 0; pend2 = 0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(7) == 0, $urandom_range(3) != 0, $urandom_range(3) != 0,
                  2'($urandom_range(3)), $urandom, 26'($urandom), $urandom_range(1, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
